// File: rtl/div_fp_iter.sv
// Iterative IEEE-754 divider (flush-to-zero, RNE); restoring division, one quotient bit per clock.
// Latency: MAN_W+6 cycles from accept to out_valid for normal operands, 2 cycles for special operands.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready.
module div_fp_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [4:0]             flags
);
    localparam int W    = EXP_W + MAN_W + 1;
    localparam int EW   = EXP_W + 2;
    localparam int QW   = MAN_W + 4;
    localparam int RW   = MAN_W + 2;
    localparam int CW   = $clog2(MAN_W + 5);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]          a_q, b_q;
    logic [RW-1:0]         rem_q;
    logic [MAN_W:0]        div_q;
    logic [QW-1:0]         quo_q;
    logic signed [EW-1:0]  exp_q;
    logic                  sign_q, spec_q;
    logic [CW-1:0]         cnt_q;

    // operand classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sa, sb, sres;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             spec;
    logic [W-1:0]     spec_out;
    logic [4:0]       spec_flg;

    assign sa   = a_q[W-1];
    assign sb   = b_q[W-1];
    assign ea   = a_q[W-2:MAN_W];
    assign eb   = b_q[W-2:MAN_W];
    assign ma   = a_q[MAN_W-1:0];
    assign mb   = b_q[MAN_W-1:0];
    assign sres = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    always_comb begin
        spec     = 1'b1;
        spec_flg = 5'b00000;
        spec_out = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        if (a_nan || b_nan) begin
            spec_flg = 5'b00000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_flg = 5'b10000;
        end else if (a_inf) begin
            spec_out = {sres, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_out = {sres, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_out = {sres, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flg = 5'b01000;
        end else if (a_zero) begin
            spec_out = {sres, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // restoring step; remainder stays below twice the divisor so one compare suffices
    logic          rem_ge;
    logic [RW-1:0] rem_sub;
    assign rem_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    // normalise, round to nearest even, range check
    logic [QW-1:0]        norm;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [MAN_W-1:0]     frac;
    logic                 g, r, st, up, inexact;
    logic [MAN_W:0]       mant_r;
    logic [W-1:0]         res;
    logic [4:0]           res_flg;

    always_comb begin
        norm    = quo_q[QW-1] ? quo_q : (quo_q << 1);
        exp_n   = quo_q[QW-1] ? exp_q : (exp_q - EW'(1));
        frac    = norm[QW-2:3];
        g       = norm[2];
        r       = norm[1];
        st      = norm[0] | (rem_q != '0);
        up      = g & (r | st | frac[0]);
        inexact = g | r | st;
        mant_r  = {1'b0, frac} + {{MAN_W{1'b0}}, up};
        exp_r   = exp_n + EW'(mant_r[MAN_W]);
        res     = {sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        res_flg = {4'b0000, inexact};
        if (exp_r >= EMAX) begin
            res     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flg = 5'b00101;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            res     = {sign_q, {(W-1){1'b0}}};
            res_flg = 5'b00011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_UNPACK;
            end
            // specials skip the divide but still use the ROUND slot
            S_UNPACK: state_nxt = spec ? S_ROUND : S_DIVIDE;
            S_DIVIDE: if (cnt_q == '0) state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                end
                S_UNPACK: begin
                    sign_q <= sres;
                    spec_q <= spec;
                    rem_q  <= {2'b01, ma};
                    div_q  <= {1'b1, mb};
                    quo_q  <= '0;
                    exp_q  <= EW'(ea) - EW'(eb) + EW'(BIAS);
                    cnt_q  <= CW'(MAN_W + 3);
                    if (spec) begin
                        out   <= spec_out;
                        flags <= spec_flg;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_sub << 1;
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                S_ROUND: if (!spec_q) begin
                    out   <= res;
                    flags <= res_flg;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_fp_iter.sv
// Bench for div_fp_iter: single-precision directed and random operations against an
// exact-integer reference, plus handshake, reset-abort and double-precision cases.
module tb_div_fp_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_a, s_b, s_out;
    logic [4:0]  s_flags;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_a, d_b, d_out;
    logic [4:0]  d_flags;

    div_fp_iter u_sp (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out(s_out), .flags(s_flags)
    );

    div_fp_iter #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out(d_out), .flags(d_flags)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: exact integer quotient, rounding decided from the exact remainder
    task automatic ref_sp(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic [4:0] flg, output bit spec);
        bit     s, an, bn, ai, bi, az, bz, up;
        int     ea, eb, e;
        longint ma, mb, num, q, rm, mant, frac4;
        s  = x[31] ^ y[31];
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = longint'({1'b1, x[22:0]});
        mb = longint'({1'b1, y[22:0]});
        an = (ea == 255) && (x[22:0] != 0);
        bn = (eb == 255) && (y[22:0] != 0);
        ai = (ea == 255) && (x[22:0] == 0);
        bi = (eb == 255) && (y[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        spec = 1'b1;
        flg  = 5'b00000;
        res  = 32'h7FC00000;
        if (an || bn) begin
            res = 32'h7FC00000;
        end else if ((az && bz) || (ai && bi)) begin
            flg = 5'b10000;
        end else if (ai) begin
            res = {s, 8'hFF, 23'h0};
        end else if (bi) begin
            res = {s, 31'h0};
        end else if (bz) begin
            res = {s, 8'hFF, 23'h0};
            flg = 5'b01000;
        end else if (az) begin
            res = {s, 31'h0};
        end else begin
            spec = 1'b0;
            e = ea - eb + 127;
            if (ma < mb) begin
                num = ma << 26;
                e   = e - 1;
            end else begin
                num = ma << 25;
            end
            q     = num / mb;
            rm    = num % mb;
            mant  = q >> 2;
            frac4 = (q % 4) * mb + rm;   // fraction beyond the LSB, in units of 1/(4*mb)
            up    = (2 * frac4 > 4 * mb) || ((2 * frac4 == 4 * mb) && (mant % 2 == 1));
            mant  = mant + longint'(up);
            if (mant == 64'd16777216) begin
                mant = 64'd8388608;
                e    = e + 1;
            end
            if (e >= 255) begin
                res = {s, 8'hFF, 23'h0};
                flg = 5'b00101;
            end else if (e <= 0) begin
                res = {s, 31'h0};
                flg = 5'b00011;
            end else begin
                res = {s, 8'(e), 23'(mant)};
                flg = {4'b0000, frac4 != 0};
            end
        end
    endtask

    function automatic logic [31:0] rnd_sp();
        int          k = $urandom_range(0, 15);
        logic [7:0]  e;
        logic [22:0] m = 23'($urandom);
        if (k == 0)      e = 8'h00;
        else if (k == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) m = '0;
        end
        else if (k < 6)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, m};
    endfunction

    // issue one operation, wait for the result, optionally stall out_ready for 'hold' cycles
    task automatic run_op(input bit dp, input logic [63:0] x, input logic [63:0] y, input int hold,
                          output logic [63:0] res, output logic [4:0] flg, output int lat);
        @(negedge clk);
        check("in_ready_idle", dp ? d_in_ready : s_in_ready, 1);
        if (dp) begin
            d_a = x; d_b = y; d_in_valid = 1'b1; d_out_ready = (hold == 0);
        end else begin
            s_a = x[31:0]; s_b = y[31:0]; s_in_valid = 1'b1; s_out_ready = (hold == 0);
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
        lat = 0;
        while (!(dp ? d_out_valid : s_out_valid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) check("timeout_out_valid", dp ? d_out_valid : s_out_valid, 1);
        res = dp ? d_out : {32'h0, s_out};
        flg = dp ? d_flags : s_flags;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out", dp ? d_out : {32'h0, s_out}, res);
            check("hold_flags", dp ? d_flags : s_flags, flg);
            check("hold_valid", dp ? d_out_valid : s_out_valid, 1);
            check("hold_in_ready", dp ? d_in_ready : s_in_ready, 0);
        end
        s_out_ready = 1'b1;
        d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", dp ? d_out_valid : s_out_valid, 0);
        check("out_kept", dp ? d_out : {32'h0, s_out}, res);
    endtask

    logic [31:0] dir_a   [9] = '{32'h40C00000, 32'h3F800000, 32'hC1200000, 32'h3F800000, 32'h00000000,
                                 32'hC0000000, 32'h7FC00001, 32'h7F000000, 32'h00800000};
    logic [31:0] dir_b   [9] = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h00000000, 32'h00000000,
                                 32'h7F800000, 32'h3F800000, 32'h3E800000, 32'h40000000};
    logic [31:0] dir_out [9] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0000000, 32'h7F800000, 32'h7FC00000,
                                 32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [4:0]  dir_flg [9] = '{5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b10000,
                                 5'b00000, 5'b00000, 5'b00101, 5'b00011};
    int          dir_lat [9] = '{29, 29, 29, 2, 2, 2, 2, 29, 29};

    initial begin
        logic [63:0] res;
        logic [4:0]  flg;
        logic [31:0] ra, rb, er;
        logic [4:0]  ef;
        bit          sp;
        int          lat, seen;

        rst = 1'b1;
        s_in_valid = 0; s_out_ready = 1; s_a = '0; s_b = '0;
        d_in_valid = 0; d_out_ready = 1; d_a = '0; d_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", s_in_ready, 1);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out", s_out, 0);
        check("rst_flags", s_flags, 0);
        check("rst_dp_in_ready", d_in_ready, 1);
        check("rst_dp_out_valid", d_out_valid, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, {32'h0, dir_a[i]}, {32'h0, dir_b[i]}, 0, res, flg, lat);
            check($sformatf("dir%0d_out", i), res, {32'h0, dir_out[i]});
            check($sformatf("dir%0d_flags", i), flg, dir_flg[i]);
            check($sformatf("dir%0d_lat", i), lat, dir_lat[i]);
        end

        for (int i = 0; i < 200; i++) begin
            ra = rnd_sp();
            rb = rnd_sp();
            ref_sp(ra, rb, er, ef, sp);
            run_op(1'b0, {32'h0, ra}, {32'h0, rb}, int'($urandom_range(0, 2)), res, flg, lat);
            check($sformatf("rnd_out %h/%h", ra, rb), res, {32'h0, er});
            check($sformatf("rnd_flags %h/%h", ra, rb), flg, ef);
            check("rnd_lat", lat, sp ? 2 : 29);
        end

        // stalled consumer, then an immediate back-to-back operation
        run_op(1'b0, 64'h40C00000, 64'h40000000, 10, res, flg, lat);
        check("stall_out", res, 64'h40400000);
        check("stall_flags", flg, 0);
        run_op(1'b0, 64'h3F800000, 64'h40400000, 0, res, flg, lat);
        check("b2b_out", res, 64'h3EAAAAAB);
        check("b2b_flags", flg, 5'b00001);

        // reset during the tenth divide iteration aborts without a result
        @(negedge clk);
        s_a = 32'h40C00000; s_b = 32'h40000000; s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", s_in_ready, 1);
        check("abort_out_valid", s_out_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (s_out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_op(1'b0, 64'h40C00000, 64'h40000000, 0, res, flg, lat);
        check("post_abort_out", res, 64'h40400000);
        check("post_abort_lat", lat, 29);

        run_op(1'b1, 64'h4018000000000000, 64'h4000000000000000, 0, res, flg, lat);
        check("dp_6div2_out", res, 64'h4008000000000000);
        check("dp_6div2_flags", flg, 0);
        check("dp_6div2_lat", lat, 58);
        run_op(1'b1, 64'h3FF0000000000000, 64'h4008000000000000, 0, res, flg, lat);
        check("dp_third_out", res, 64'h3FD5555555555555);
        check("dp_third_flags", flg, 5'b00001);
        run_op(1'b1, 64'h0000000000000000, 64'h8000000000000000, 0, res, flg, lat);
        check("dp_zz_out", res, 64'h7FF8000000000000);
        check("dp_zz_flags", flg, 5'b10000);
        check("dp_zz_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
